// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the 8088-style bus slice: address/data bus widths,
// the target's one-hot state encoding, the address-phase timeout length and
// the parity helper used when the storage array carries a check bit.
// ---------------------------------------------------------------------------
package bus_pkg;

    localparam int ADDR_BUS_W  = 20;
    localparam int DATA_W      = 8;
    localparam int TIMEOUT_CYC = 4;

    // Last value of the 2-bit address-phase counter before the target gives up
    localparam logic [1:0] TIMEOUT_LAST = 2'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        ADDR  = 4'b0010,
        READ  = 4'b0100,
        WRITE = 4'b1000
    } tgt_state_t;

    // Even parity: the stored check bit makes the total count of ones even
    function automatic logic evenParity(input logic [DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/bus_mem_array.sv
// ---------------------------------------------------------------------------
// bus_mem_array
// Byte-wide (optionally byte + parity) storage behind the bus target.
// Single address shared by the synchronous write and the asynchronous read,
// because the target only ever touches the one latched address per cycle.
//
// Parameters:
//   ADDR_W  log2 of the depth in words
//   WIDTH   word width in bits
// Ports:
//   clock    in   system clock, write happens on the rising edge
//   i_we     in   write enable
//   i_addr   in   word address for both read and write
//   i_wdata  in   write data
//   o_rdata  out  combinational read data at i_addr
// ---------------------------------------------------------------------------
module bus_mem_array #(
    parameter int ADDR_W = 8,
    parameter int WIDTH  = 8
) (
    input  logic              clock,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WIDTH-1:0]  i_wdata,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [2**ADDR_W];

    // Contents are deliberately not reset; software must write before reading
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read is combinational so the target can register data on the strobe edge
    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/bus_mem_target.sv
// ---------------------------------------------------------------------------
// bus_mem_target
// Memory/IO target sitting behind one bus-cycle FSM. It latches and decodes
// the multiplexed address on ALE, then services a single read (OEb) or write
// (WR_RDb) strobe. Read data is driven for exactly one cycle.
//
// Build option: define PARITY_EN to store an even-parity bit with every byte
// and flag a sticky par_err when a read finds a mismatch. Without it the
// array is 8 bits wide and par_err is tied low.
//
// Parameters:
//   IOM        space answered (0 = memory, 1 = IO), must match the FSM
//   ADDR_W     log2 of array depth in bytes (4..12)
//   BASE_ADDR  window base, only bits [19:ADDR_W] are compared
// Ports:
//   clock    in   system clock
//   reset    in   synchronous active-high reset
//   ALE      in   address latch enable, one cycle at bus-cycle start
//   iom_in   in   space qualifier, valid with ALE
//   addr_hi  in   A[19:8], valid with ALE
//   ad_in    in   AD[7:0]: address low byte with ALE, write data with WR_RDb
//   OEb      in   read strobe
//   WR_RDb   in   write strobe
//   ad_out   out  read data
//   ad_oe    out  AD bus output enable, one cycle per read
//   sel      out  registered decode hit for the latched address
//   par_err  out  sticky parity error
// ---------------------------------------------------------------------------
module bus_mem_target
    import bus_pkg::*;
#(
    parameter logic                  IOM       = 1'b0,
    parameter int                    ADDR_W    = 8,
    parameter logic [ADDR_BUS_W-1:0] BASE_ADDR = 20'h00000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ALE,
    input  logic              iom_in,
    input  logic [11:0]       addr_hi,
    input  logic [DATA_W-1:0] ad_in,
    input  logic              OEb,
    input  logic              WR_RDb,
    output logic [DATA_W-1:0] ad_out,
    output logic              ad_oe,
    output logic              sel,
    output logic              par_err
);

`ifdef PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    tgt_state_t              r_state;
    tgt_state_t              w_nextState;
    logic [ADDR_BUS_W-1:0]   r_addrQ;
    logic                    r_iomQ;
    logic                    r_sel;
    logic [DATA_W-1:0]       r_adOut;
    logic                    r_adOe;
    logic [1:0]              r_toCount;
    logic [1:0]              w_toNext;
    logic                    w_latch;
    logic                    w_doRead;
    logic                    w_doWrite;
    logic                    w_memWe;
    logic [ADDR_BUS_W-1:0]   w_newAddr;
    logic                    w_decodeHit;
    logic                    w_latchedHit;
    logic [MEM_W-1:0]        w_memWdata;
    logic [MEM_W-1:0]        w_memRdata;

    assign w_newAddr = {addr_hi, ad_in};

    // Decode of the address currently on the bus, captured into sel on ALE
    assign w_decodeHit = (iom_in == IOM) &&
                         (w_newAddr[ADDR_BUS_W-1:ADDR_W] == BASE_ADDR[ADDR_BUS_W-1:ADDR_W]);

    // Access qualifier from the latched copy; equals r_sel by construction
    assign w_latchedHit = r_sel && (r_iomQ == IOM) &&
                          (r_addrQ[ADDR_BUS_W-1:ADDR_W] == BASE_ADDR[ADDR_BUS_W-1:ADDR_W]);

    // A write strobe coinciding with reset must never reach the array
    assign w_memWe = w_doWrite && !reset;

`ifdef PARITY_EN
    assign w_memWdata = {evenParity(ad_in), ad_in};
`else
    assign w_memWdata = ad_in;
`endif

    bus_mem_array #(
        .ADDR_W (ADDR_W),
        .WIDTH  (MEM_W)
    ) u_memArray (
        .clock   (clock),
        .i_we    (w_memWe),
        .i_addr  (r_addrQ[ADDR_W-1:0]),
        .i_wdata (w_memWdata),
        .o_rdata (w_memRdata)
    );

    // Next-state and access decisions. ALE always wins over the strobes while
    // in ADDR; both strobes together is treated as an illegal cycle and
    // abandoned. The timeout counter only advances while waiting in ADDR
    // with no strobe, and reads zero everywhere else so every entry to ADDR
    // starts a fresh count.
    always_comb begin
        w_nextState = r_state;
        w_latch     = 1'b0;
        w_doRead    = 1'b0;
        w_doWrite   = 1'b0;
        w_toNext    = 2'd0;
        case (r_state)
            IDLE: begin
                if (ALE) begin
                    w_latch     = 1'b1;
                    w_nextState = ADDR;
                end
            end
            ADDR: begin
                if (ALE) begin
                    w_latch     = 1'b1;
                    w_nextState = ADDR;
                end else if (OEb && WR_RDb) begin
                    w_nextState = IDLE;
                end else if (OEb || WR_RDb) begin
                    if (!w_latchedHit) begin
                        w_nextState = IDLE;
                    end else if (OEb) begin
                        w_doRead    = 1'b1;
                        w_nextState = READ;
                    end else begin
                        w_doWrite   = 1'b1;
                        w_nextState = WRITE;
                    end
                end else if (r_toCount == TIMEOUT_LAST) begin
                    w_nextState = IDLE;
                end else begin
                    w_toNext = r_toCount + 2'd1;
                end
            end
            READ:    w_nextState = IDLE;
            WRITE:   w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // State, address latch and read-data registers. ad_oe follows the read
    // decision directly, so it is high for exactly the one cycle spent in
    // READ and drops on the exit edge. ad_out holds its last value after.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_addrQ   <= '0;
            r_iomQ    <= 1'b0;
            r_sel     <= 1'b0;
            r_adOut   <= '0;
            r_adOe    <= 1'b0;
            r_toCount <= 2'd0;
        end else begin
            r_state   <= w_nextState;
            r_toCount <= w_toNext;
            r_adOe    <= w_doRead;
            if (w_latch) begin
                r_addrQ <= w_newAddr;
                r_iomQ  <= iom_in;
                r_sel   <= w_decodeHit;
            end
            if (w_doRead) begin
                r_adOut <= w_memRdata[DATA_W-1:0];
            end
        end
    end

`ifdef PARITY_EN
    logic r_parErr;

    // Parity is rechecked on the same edge that launches the read data, and
    // the error flag stays set until the next reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_parErr <= 1'b0;
        end else if (w_doRead &&
                     (w_memRdata[DATA_W] != evenParity(w_memRdata[DATA_W-1:0]))) begin
            r_parErr <= 1'b1;
        end
    end

    assign par_err = r_parErr;
`else
    assign par_err = 1'b0;
`endif

    assign ad_out = r_adOut;
    assign ad_oe  = r_adOe;
    assign sel    = r_sel;

endmodule
